// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register: default sizes and the
// occupancy encoding reported to the outside world.
package pipe_pkg;

   localparam int DEF_WIDTH = 128;
   localparam int DEF_CNT_W = 16;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

   function automatic logic [1:0] occ_of(input logic main_valid, input logic skid_valid);
      logic [1:0] occ;
      case ({main_valid, skid_valid})
         2'b00:   occ = OCC_EMPTY;
         2'b11:   occ = OCC_TWO;
         default: occ = OCC_ONE;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter
   import pipe_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with a skid register, giving full throughput
// with in_ready driven straight from a flop; also keeps stall/flush stats.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int CNT_W       = DEF_CNT_W,
   parameter bit BUBBLE_ZERO = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             clr_cnt,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] main_data_q,  main_data_d;
   logic [WIDTH-1:0] skid_data_q,  skid_data_d;
   logic             in_hs;
   logic             out_hs;

   assign in_ready = ~skid_valid_q;
   assign in_hs    = in_valid & ~skid_valid_q;
   assign out_hs   = main_valid_q & out_ready;

   // Skid only ever fills while main is full, so a full skid blocks input.
   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         if (out_ready) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end
      end else if (in_hs) begin
         if (main_valid_q && !out_ready) begin
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
         end else begin
            main_data_d  = in_data;
            main_valid_d = 1'b1;
         end
      end else if (out_hs) begin
         main_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign out_valid = main_valid_q;
   assign out_data  = (BUBBLE_ZERO && !main_valid_q) ? '0 : main_data_q;
   assign occupancy = occ_of(main_valid_q, skid_valid_q);

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (main_valid_q & ~out_ready),
      .clr     (clr_cnt),
      .count   (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (flush & (occupancy != OCC_EMPTY)),
      .clr     (clr_cnt),
      .count   (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios then random traffic, all
// checked every cycle against a queue-based model of the stage.
module tb_pipe_stage_reg;

   localparam int W  = 8;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          flush = 1'b0;
   logic          clr_cnt = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_data;
   logic [1:0]    occupancy;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;

   int total = 0;
   int bad   = 0;

   // Model: beats held in acceptance order, plus the two statistics.
   int m_q[$];
   int m_stall = 0;
   int m_flush = 0;

   pipe_stage_reg #(.WIDTH(W), .CNT_W(CW), .BUBBLE_ZERO(1'b1)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .clr_cnt   (clr_cnt),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit acc;
      bit held;
      held = (m_q.size() > 0);
      if (clr_cnt) begin
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (held && !out_ready && m_stall < CMAX) m_stall++;
         if (held && flush && m_flush < CMAX) m_flush++;
      end
      if (flush) begin
         m_q.delete();
      end else begin
         acc = in_valid && (m_q.size() < 2);
         if (held && out_ready) void'(m_q.pop_front());
         if (acc) m_q.push_back(int'(in_data));
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_stall = 0;
      m_flush = 0;
   endtask

   task automatic check_all(input string tag);
      int exp_data;
      exp_data = (m_q.size() > 0) ? m_q[0] : 0;
      chk({tag, ".occupancy"}, 32'(occupancy), 32'(m_q.size()));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
      chk({tag, ".out_data"},  32'(out_data),  32'(exp_data));
      chk({tag, ".in_ready"},  32'(in_ready),  32'(m_q.size() < 2));
      chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
      chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
      $display("cyc %s in_v=%0d in_d=%0h out_r=%0d flush=%0d clr=%0d -> occ=%0d out_v=%0d out_d=%0h in_r=%0d stall=%0d fl=%0d",
               tag, in_valid, in_data, out_ready, flush, clr_cnt, occupancy, out_valid, out_data,
               in_ready, stall_cnt, flush_cnt);
   endtask

   // One clock: model follows the inputs seen at the edge, outputs checked 1ns later.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all({tag, ".async"});
      @(posedge clk);
      #1;
      check_all({tag, ".held"});
      reset_n = 1'b1;
   endtask

   initial begin
      #2;
      do_reset("por");

      // Single beat, one-cycle latency.
      in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
      step("beat_a5");
      chk("a5.out_data_const", 32'(out_data), 32'h0000_00A5);
      in_valid = 1'b0;
      step("drain_a5");

      // Back-to-back 1,2,3 with downstream stalled.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'd1; step("fill_1");
      in_data = 8'd2; step("fill_2");
      in_data = 8'd3; step("fill_3_held");
      chk("full.in_ready_const", 32'(in_ready), 32'd0);
      chk("full.occ_const", 32'(occupancy), 32'd2);

      // Release downstream; beat 3 goes in once in_ready returns.
      out_ready = 1'b1;
      step("pop_1");
      chk("pop1.out_data_const", 32'(out_data), 32'd2);
      step("pop_2");
      chk("pop2.out_data_const", 32'(out_data), 32'd3);
      in_valid = 1'b0;
      step("pop_3");

      // Flush with two held beats and a beat offered in the same cycle.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h11; step("ffill_1");
      in_data = 8'h22; step("ffill_2");
      flush = 1'b1; in_data = 8'h33; step("flush_full");
      chk("flush.occ_const", 32'(occupancy), 32'd0);
      in_valid = 1'b0; step("flush_empty");
      flush = 1'b0;

      // Stall saturation then clear, clear winning over a same-cycle increment.
      in_valid = 1'b1; in_data = 8'h5C; step("sat_load");
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) step("sat_stall");
      chk("sat.stall_const", 32'(stall_cnt), 32'(CMAX));
      clr_cnt = 1'b1; step("sat_clr");
      chk("clr.stall_const", 32'(stall_cnt), 32'd0);
      clr_cnt = 1'b0;
      out_ready = 1'b1; step("sat_drain");

      // Random traffic with a mid-stream reset pulse.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = W'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         clr_cnt   = ($urandom_range(0, 39) == 0);
         if (i == 200) begin
            do_reset("rnd_reset");
         end else begin
            step("rnd");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
